// File: rtl/fs4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fs4_seq_ctrl -- multi-precision subtraction sequencer
//
// Computes d = a - b - bin over W = 4*NIBBLES bits by walking the operands one
// nibble per cycle, LSB nibble first, through a single 4-bit full-subtractor
// slice. Each nibble's borrow-out feeds the next nibble's borrow-in.
//
// Handshake: start is accepted only while ready=1 (IDLE). The operands and the
// initial borrow are captured on acceptance. The op then spends NIBBLES cycles
// in RUN and one cycle in DONE. done pulses for one cycle together with the
// updated d_out/bo_out. Those outputs then hold until the next done.
//
// Optional build macro:
//   FS4_SEQ_SAT_EN  unsigned saturating subtract. A final borrow of 1 forces
//                   d_out to 0; bo_out still reports the borrow. Timing is
//                   the same.
//
// Parameters:
//   NIBBLES  nibbles per operand, 1..16 (operand width W = 4*NIBBLES)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, accepted when ready=1
//   a_in    in   W-bit minuend, sampled on acceptance
//   b_in    in   W-bit subtrahend, sampled on acceptance
//   bin     in   initial borrow-in, sampled on acceptance
//   ready   out  high only in IDLE
//   busy    out  high in RUN or DONE
//   done    out  one-cycle pulse; d_out/bo_out are valid from this cycle on
//   d_out   out  W-bit difference, held until the next done
//   bo_out  out  final borrow-out, held with d_out
// -----------------------------------------------------------------------------

// 4-bit full subtractor: {bo, d} = a - b - c.
module fs4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] d,
  output logic       bo
);
  logic [4:0] diff;

  // Bit 4 of a 5-bit difference is set exactly when a < b + c.
  assign diff = {1'b0, a} - {1'b0, b} - {4'b0000, c};
  assign d    = diff[3:0];
  assign bo   = diff[4];
endmodule

module fs4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 bin,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] d_out,
  output logic                 bo_out
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     d_out_q, d_out_d;
  logic             bo_out_q, bo_out_d;
  logic             done_q, done_d;

  logic [3:0]       slice_d;
  logic             slice_bo;

  // The shared slice always looks at the nibble selected by idx. Its output is
  // only consumed while in RUN.
  fs4_slice u_slice (
    .a  (a_q[4*idx_q +: 4]),
    .b  (b_q[4*idx_q +: 4]),
    .c  (borrow_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    d_out_d  = d_out_q;
    bo_out_d = bo_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        result_d[4*idx_q +: 4] = slice_d;
        borrow_d               = slice_bo;
        // idx stops at the last nibble; acceptance is the only thing that
        // brings it back to zero.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        // borrow_q now holds the borrow out of the top nibble.
`ifdef FS4_SEQ_SAT_EN
        d_out_d = borrow_q ? '0 : result_q;
`else
        d_out_d = result_q;
`endif
        bo_out_d = borrow_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the statements are in.
  // The operand and result registers are reset together with the control
  // state. They are small, and resetting them keeps the slice inputs defined
  // out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      d_out_q  <= '0;
      bo_out_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      d_out_q  <= d_out_d;
      bo_out_q <= bo_out_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = done_q;
  assign d_out  = d_out_q;
  assign bo_out = bo_out_q;

endmodule

// File: tb/tb_fs4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fs4_seq_ctrl -- scoreboard bench for fs4_seq_ctrl (NIBBLES=4)
//
// The driver issues ops and pushes the model's expected result and the
// acceptance cycle into a queue. The monitor pops an entry on every done and
// compares the data, the latency and the spacing between dones. The reference
// model is plain wide-integer arithmetic on the whole operands.
// -----------------------------------------------------------------------------
module tb_fs4_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         bin   = 1'b0;
  logic         ready, busy, done, bo_out;
  logic [W-1:0] d_out;

  fs4_seq_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .bin    (bin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .d_out  (d_out),
    .bo_out (bo_out)
  );

  always #5 clk = ~clk;

  // Count of rising edges since time zero.
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] shown_d  = '0;
  logic         shown_bo = 1'b0;
  int           last_done = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The result is the full-width difference. A negative value means a borrow
  // out of the top bit.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                           output logic [W-1:0] d, output logic bo);
    longint diff;
    diff = longint'(a) - longint'(b) - longint'(bi);
    bo   = (diff < 0);
    d    = W'(diff);
`ifdef FS4_SEQ_SAT_EN
    if (bo) d = '0;
`endif
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("d_out", d_out, e.d);
        check("bo_out", bo_out, e.bo);
        check("latency", cycle - e.acc, N + 1);
        if (last_done >= 0) check("done_spacing_ok", (cycle - last_done) >= N + 2, 1);
        last_done = cycle;
      end
    end
  end

  // Called on a falling edge while the DUT is idle. Returns on the falling
  // edge after done, with ready high, so the next call is back-to-back.
  // pulse_busy drives start with a=FFFF throughout RUN and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit pulse_busy);
    exp_t e;
    check("ready_before_start", ready, 1);
    a_in  = a;
    b_in  = b;
    bin   = bi;
    start = 1'b1;
    ref_model(a, b, bi, e.d, e.bo);
    e.acc = cycle + 1;
    exp_q.push_back(e);
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      if (k <= N) begin
        check("busy_in_op", busy, 1);
        check("ready_in_op", ready, 0);
        check("d_out_held", d_out, shown_d);
        check("bo_out_held", bo_out, shown_bo);
        if (pulse_busy) begin
          start = 1'b1;
          a_in  = '1;
        end else begin
          start = 1'b0;
          a_in  = W'($urandom);
          b_in  = W'($urandom);
          bin   = 1'($urandom);
        end
      end else begin
        check("ready_after_done", ready, 1);
        check("busy_after_done", busy, 0);
        start = 1'b0;
      end
    end
    shown_d  = e.d;
    shown_bo = e.bo;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbi;
    int           gap;
    int           dones_before;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d_out", d_out, 0);
    check("rst_bo_out", bo_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(16'h1234, 16'h0034, 1'b0, 1'b0);  // T1: 0x1200, no borrow
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);  // T2: wrap (or saturate)
    run_op(16'h8000, 16'h0000, 1'b1, 1'b0);  // T3: borrow ripples up to the top nibble
    run_op(16'h0005, 16'h0003, 1'b0, 1'b1);  // T4: start pulsed while busy is ignored
    @(negedge clk);
    check("t4_idle_ready", ready, 1);
    check("t4_d_out_kept", d_out, 16'h0002);
    run_op(16'h8000, 16'h0000, 1'b1, 1'b0);  // leaves 0x7FFF visible before the abort

    // T5: async reset two cycles after acceptance aborts the op.
    check("t5_ready", ready, 1);
    a_in  = 16'hABCD;
    b_in  = 16'h0123;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_busy_pre_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_ready_async", ready, 1);
    check("t5_busy_async", busy, 0);
    check("t5_done_async", done, 0);
    check("t5_d_out_async", d_out, 0);
    check("t5_bo_out_async", bo_out, 0);
    shown_d  = '0;
    shown_bo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones_before = checks;
    repeat (N + 6) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
      check("t5_idle", ready, 1);
    end
    check("t5_d_out_after", d_out, 0);
    last_done = -1;

    // T6: random ops, mostly back-to-back with occasional idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      if (i % 10 == 0) ra = rb;  // exercise the a == b boundary
      run_op(ra, rb, rbi, ($urandom_range(0, 7) == 0));
      gap = $urandom_range(0, 3);
      if (gap == 3) gap = 0;
      repeat (gap) begin
        @(negedge clk);
        check("gap_ready", ready, 1);
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
